mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mmu_pkg.sv | 26 ++
 rtl/req_timeout_ctr.sv | 35 +++
 rtl/mem_copy_dma.sv | 194 +++++++++++++++++++
 tb/tb_mem_copy_dma.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// ============================================================================
// Module  : mmu_pkg
// Brief   : Shared state encoding and error codes for the memory-copy DMA.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } dma_state_t;

    localparam logic [1:0] c_err_none     = 2'd0;
    localparam logic [1:0] c_err_bus      = 2'd1;
    localparam logic [1:0] c_err_timeout  = 2'd2;
    localparam logic [1:0] c_err_misalign = 2'd3;

endpackage

`default_nettype wire

// File: rtl/req_timeout_ctr.sv
// ============================================================================
// Module  : req_timeout_ctr
// Brief   : Counts idle wait cycles; expired fires on the last allowed cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module req_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Asserted during the TIMEOUT_CYCLES-th consecutive idle wait cycle.
    assign expired = enable && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/mem_copy_dma.sv
// ============================================================================
// Module  : mem_copy_dma
// Brief   : Word-by-word memory copy engine, one outstanding request at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_dma
    import mmu_pkg::*;
#(
    parameter int MEM_W          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [15:0]          len_words,
    output logic                 mem_req_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_we_o,
    output logic [MEM_W/8-1:0]   mem_be_o,
    output logic [MEM_W-1:0]     mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic                 mem_err_i,
    input  logic [MEM_W-1:0]     mem_rdata_i,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [31:0]          err_addr
);

    dma_state_t       r_state;
    dma_state_t       w_state_nxt;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [15:0]      r_len;
    logic [MEM_W-1:0] r_data;
    logic             r_done;
    logic             r_error;
    logic [1:0]       r_err_code;
    logic [31:0]      r_err_addr;

    logic w_misaligned;
    logic w_in_wait;
    logic w_tmo_en;
    logic w_expired;

    assign w_misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
    assign w_in_wait    = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
    assign w_tmo_en     = w_in_wait && !mem_rvalid_i && !mem_err_i;

    req_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_in_wait),
        .enable  (w_tmo_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !w_misaligned) begin
                    w_state_nxt = (len_words == 16'd0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (mem_err_i || w_expired) w_state_nxt = ST_IDLE;
                else if (mem_rvalid_i)      w_state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ:  w_state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (mem_err_i || w_expired) w_state_nxt = ST_IDLE;
                else if (mem_rvalid_i)      w_state_nxt = (r_len == 16'd1) ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= c_err_none;
            r_err_addr <= '0;
        end else begin
            r_done <= (r_state == ST_DONE) && !abort;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_misaligned) begin
                            r_error    <= 1'b1;
                            r_err_code <= c_err_misalign;
                            r_err_addr <= src_addr;
                        end else begin
                            r_error    <= 1'b0;
                            r_err_code <= c_err_none;
                            r_err_addr <= '0;
                            r_src      <= src_addr;
                            r_dst      <= dst_addr;
                            r_len      <= len_words;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (!abort) begin
                        if (mem_err_i) begin
                            r_error    <= 1'b1;
                            r_err_code <= c_err_bus;
                            r_err_addr <= r_src;
                        end else if (mem_rvalid_i) begin
                            r_data <= mem_rdata_i;
                        end else if (w_expired) begin
                            r_error    <= 1'b1;
                            r_err_code <= c_err_timeout;
                            r_err_addr <= r_src;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (!abort) begin
                        if (mem_err_i) begin
                            r_error    <= 1'b1;
                            r_err_code <= c_err_bus;
                            r_err_addr <= r_dst;
                        end else if (mem_rvalid_i) begin
                            r_len <= r_len - 16'd1;
                            r_src <= r_src + 32'd4;
                            r_dst <= r_dst + 32'd4;
                        end else if (w_expired) begin
                            r_error    <= 1'b1;
                            r_err_code <= c_err_timeout;
                            r_err_addr <= r_dst;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Request fields are forced to zero whenever no request is being issued.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (r_state == ST_RD_REQ) begin
            mem_req_o  = 1'b1;
            mem_addr_o = r_src;
            mem_be_o   = '1;
        end else if (r_state == ST_WR_REQ) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = r_dst;
            mem_we_o    = 1'b1;
            mem_be_o    = '1;
            mem_wdata_o = r_data;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;
    assign err_addr = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
// ============================================================================
// Module  : tb_mem_copy_dma
// Brief   : Scoreboard bench: expected requests queued, monitor compares them.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        rsp_rvalid = 1'b0;
    logic        rsp_err = 1'b0;
    logic [31:0] rsp_rdata = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] err_addr;

    mem_copy_dma #(
        .MEM_W          (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len_words    (len_words),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (rsp_rvalid),
        .mem_err_i    (rsp_err),
        .mem_rdata_i  (rsp_rdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cycle_cnt = 0;
    // 0 normal, 1 never respond, 2 err+rvalid together, 3 no write response
    int          rsp_mode = 0;
    logic [31:0] err_at_addr = 32'hFFFF_FFFF;

    always @(posedge clk) cycle_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic we, input logic [31:0] wd);
        req_t r;
        r.addr = a; r.we = we; r.wdata = wd;
        exp_q.push_back(r);
    endtask

    // Monitor: every issued request must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", {31'd0, mem_req_o}, 32'd0);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    check("req_addr", mem_addr_o, e.addr);
                    check("req_we", {31'd0, mem_we_o}, {31'd0, e.we});
                    check("req_be", {28'd0, mem_be_o}, 32'hF);
                    check("req_wdata", mem_wdata_o, e.we ? e.wdata : 32'd0);
                end
            end else if (mem_addr_o != 0 || mem_wdata_o != 0 || mem_we_o || mem_be_o != 0) begin
                check("idle_bus_zero", mem_addr_o | mem_wdata_o, 32'd0);
            end
        end
    end

    // Responder: answers one cycle after a request according to rsp_mode.
    initial begin
        logic [31:0] a;
        logic        w;
        logic [31:0] wd;
        forever begin
            @(negedge clk);
            if (mem_req_o && !rst) begin
                a = mem_addr_o; w = mem_we_o; wd = mem_wdata_o;
                if (!(rsp_mode == 1 || (rsp_mode == 3 && w))) begin
                    @(posedge clk); #1;
                    if (a == err_at_addr) begin
                        rsp_err = 1'b1;
                    end else if (rsp_mode == 2) begin
                        rsp_err = 1'b1; rsp_rvalid = 1'b1;
                    end else begin
                        rsp_rvalid = 1'b1;
                        if (w) mem[a] = wd;
                        else   rsp_rdata = mem.exists(a) ? mem[a] : 32'd0;
                    end
                    @(posedge clk); #1;
                    rsp_rvalid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            output int t0);
        src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
        t0 = cycle_cnt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done || error) begin
                lat = cycle_cnt - t0;
                break;
            end
        end
    endtask

    task automatic wait_write_req();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req_o && mem_we_o) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic late_rvalid();
        rsp_rvalid = 1'b1;
        @(posedge clk); #1;
        rsp_rvalid = 1'b0;
    endtask

    initial begin
        int t0;
        int lat;
        mem[32'h1000] = 32'hA1A1_0001;
        mem[32'h1004] = 32'hB2B2_0002;
        mem[32'h1008] = 32'hC3C3_0003;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk); #1;

        // Misaligned source: error code 3, no requests
        do_start(32'h1002, 32'h1040, 16'd2, t0);
        @(negedge clk);
        check("mis_error", {31'd0, error}, 32'd1);
        check("mis_code", {30'd0, err_code}, 32'd3);
        check("mis_addr", err_addr, 32'h1002);
        check("mis_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Three-word copy; a start pulse mid-transfer must be ignored
        push_req(32'h1000, 1'b0, 0); push_req(32'h1040, 1'b1, 32'hA1A1_0001);
        push_req(32'h1004, 1'b0, 0); push_req(32'h1044, 1'b1, 32'hB2B2_0002);
        push_req(32'h1008, 1'b0, 0); push_req(32'h1048, 1'b1, 32'hC3C3_0003);
        do_start(32'h1000, 32'h1040, 16'd3, t0);
        @(negedge clk);
        check("copy_err_cleared", {31'd0, error}, 32'd0);
        check("copy_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        src_addr = 32'h2000; len_words = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end(t0, lat);
        check("copy_latency", lat, 32'd14);
        check("copy_done", {31'd0, done}, 32'd1);
        check("copy_error", {31'd0, error}, 32'd0);
        check("copy_queue_empty", exp_q.size(), 32'd0);
        check("copy_mem0", mem[32'h1040], 32'hA1A1_0001);
        check("copy_mem1", mem[32'h1044], 32'hB2B2_0002);
        check("copy_mem2", mem[32'h1048], 32'hC3C3_0003);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        @(posedge clk); #1;

        // Zero length: done one cycle after busy rises
        do_start(32'h1000, 32'h1040, 16'd0, t0);
        @(negedge clk);
        check("len0_busy", {31'd0, busy}, 32'd1);
        check("len0_no_done_yet", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_busy_low", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Bus error on the second read
        err_at_addr = 32'h1004;
        push_req(32'h1000, 1'b0, 0); push_req(32'h1040, 1'b1, 32'hA1A1_0001);
        push_req(32'h1004, 1'b0, 0);
        do_start(32'h1000, 32'h1040, 16'd3, t0);
        wait_end(t0, lat);
        check("buserr_latency", lat, 32'd7);
        check("buserr_error", {31'd0, error}, 32'd1);
        check("buserr_code", {30'd0, err_code}, 32'd1);
        check("buserr_addr", err_addr, 32'h1004);
        check("buserr_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1 err_at_addr = 32'hFFFF_FFFF;

        // Reset while idle clears the sticky error
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_clr_error", {31'd0, error}, 32'd0);
        check("rst_clr_code", {30'd0, err_code}, 32'd0);
        check("rst_clr_addr", err_addr, 32'd0);
        @(posedge clk); #1;

        // No response: timeout after 8 wait cycles
        rsp_mode = 1;
        push_req(32'h1000, 1'b0, 0);
        do_start(32'h1000, 32'h1040, 16'd1, t0);
        wait_end(t0, lat);
        check("tmo_latency", lat, 32'd10);
        check("tmo_code", {30'd0, err_code}, 32'd2);
        check("tmo_addr", err_addr, 32'h1000);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // rvalid and err together: error wins
        rsp_mode = 2;
        push_req(32'h1000, 1'b0, 0);
        do_start(32'h1000, 32'h1040, 16'd1, t0);
        wait_end(t0, lat);
        check("both_latency", lat, 32'd3);
        check("both_code", {30'd0, err_code}, 32'd1);
        check("both_addr", err_addr, 32'h1000);
        @(posedge clk); #1;

        // Abort in WR_WAIT, then a late response
        rsp_mode = 3;
        push_req(32'h1000, 1'b0, 0); push_req(32'h1040, 1'b1, 32'hA1A1_0001);
        do_start(32'h1000, 32'h1040, 16'd2, t0);
        wait_write_req();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_req", {31'd0, mem_req_o}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_error", {31'd0, error}, 32'd0);
        @(posedge clk); #1;
        late_rvalid();
        repeat (3) @(negedge clk);
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;

        // Reset in WR_WAIT, then a late response
        push_req(32'h1000, 1'b0, 0); push_req(32'h1040, 1'b1, 32'hA1A1_0001);
        do_start(32'h1000, 32'h1040, 16'd2, t0);
        wait_write_req();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_busy", {31'd0, busy}, 32'd0);
        check("rstw_req", {31'd0, mem_req_o}, 32'd0);
        check("rstw_done", {31'd0, done}, 32'd0);
        check("rstw_error", {31'd0, error}, 32'd0);
        @(posedge clk); #1;
        late_rvalid();
        repeat (3) @(negedge clk);
        check("rstw_late_busy", {31'd0, busy}, 32'd0);
        check("rstw_late_done", {31'd0, done}, 32'd0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
